instr_sequencer: RTL and testbench

INSTR_SEQUENCER -- requirements
Module: instr_sequencer

---
 rtl/instr_sequencer_pkg.sv | 24 ++
 rtl/instr_sequencer_if.sv | 36 +++
 rtl/instr_sequencer_watchdog.sv | 39 +++
 rtl/instr_sequencer.sv | 126 ++++++++++++
 tb/tb_instr_sequencer.sv | 296 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/instr_sequencer_pkg.sv
// Shared MCU definitions: opcode constants, the NOP instruction word and the
// instruction sequencer state encoding.
package mcu_pkg;

  localparam logic [3:0] OP_NOP  = 4'b0000;
  localparam logic [3:0] OP_MOV  = 4'b0100;
  localparam logic [3:0] OP_HALT = 4'b1111;

  localparam logic [15:0] NOP_WORD = 16'h0000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_LOAD,
    ST_EXEC,
    ST_CLEAR,
    ST_HALT
  } seq_state_e;

  function automatic logic [3:0] opcode_of(input logic [15:0] word);
    return word[15:12];
  endfunction

endpackage

// File: rtl/instr_sequencer_if.sv
// Sequencer <-> memory/opcode-FSM bus. The sequencer is the master.
// Optional single-step input is present only when SEQ_STEP_EN is defined.
interface instr_sequencer_if #(
  parameter int PC_W = 8
);

  logic            run;
  logic [15:0]     mem_data;
  logic            done;
  logic            pc_inc;
`ifdef SEQ_STEP_EN
  logic            step;
`endif
  logic [PC_W-1:0] pc;
  logic [15:0]     instruction;
  logic            busy;
  logic            halted;
  logic            fault;

  modport master (
    input  run, mem_data, done, pc_inc,
`ifdef SEQ_STEP_EN
    input  step,
`endif
    output pc, instruction, busy, halted, fault
  );

  modport slave (
    output run, mem_data, done, pc_inc,
`ifdef SEQ_STEP_EN
    output step,
`endif
    input  pc, instruction, busy, halted, fault
  );

endinterface

// File: rtl/instr_sequencer_watchdog.sv
// EXEC-phase watchdog: counts EXEC cycles and flags the TIMEOUT-th one.
module seq_watchdog #(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // cnt_q holds the number of EXEC cycles already completed, so the
  // TIMEOUT-th cycle is the one where it equals TIMEOUT-1.
  assign expired_o = enable_i && (cnt_q == CNT_W'(TIMEOUT - 1));

  always_comb begin
    // NOTE: cnt_d gets a default before any branch so no latch is inferred.
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (enable_i && !expired_o) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/instr_sequencer.sv
// Instruction sequencer: FETCH/LOAD/EXEC/CLEAR loop with EXEC watchdog.
// Define SEQ_STEP_EN to run exactly one instruction per step pulse.
module instr_sequencer #(
  parameter int PC_W    = 8,
  parameter int TIMEOUT = 15
) (
  input logic               clk,
  input logic               rst,
  instr_sequencer_if.master bus
);

  import mcu_pkg::*;

  seq_state_e      state_q;
  logic [PC_W-1:0] pc_q;
  logic [15:0]     instr_q;
  logic            busy_q;
  logic            halted_q;
  logic            fault_q;

  logic            launch;
  logic            rearm;
  logic            wd_enable;
  logic            wd_clear;
  logic            wd_expired;

`ifdef SEQ_STEP_EN
  assign launch = bus.run & bus.step;
  assign rearm  = 1'b0;
`else
  assign launch = bus.run;
  assign rearm  = bus.run;
`endif

  assign wd_enable = (state_q == ST_EXEC);
  assign wd_clear  = !wd_enable;

  seq_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk       (clk),
    .rst       (rst),
    .clear_i   (wd_clear),
    .enable_i  (wd_enable),
    .expired_o (wd_expired)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      pc_q     <= '0;
      instr_q  <= NOP_WORD;
      busy_q   <= 1'b0;
      halted_q <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking updates so every branch sees pre-edge state.
      unique case (state_q)
        ST_IDLE: begin
          if (launch) begin
            state_q <= ST_FETCH;
            busy_q  <= 1'b1;
          end
        end

        ST_FETCH: begin
          state_q <= ST_LOAD;
        end

        ST_LOAD: begin
          // A HALT opcode is latched and immediately replaced by NOP.
          if (opcode_of(bus.mem_data) == OP_HALT) begin
            state_q  <= ST_HALT;
            instr_q  <= NOP_WORD;
            busy_q   <= 1'b0;
            halted_q <= 1'b1;
          end else begin
            state_q <= ST_EXEC;
            instr_q <= bus.mem_data;
          end
        end

        ST_EXEC: begin
          if (bus.pc_inc) begin
            pc_q <= pc_q + PC_W'(1);
          end
          if (bus.done) begin
            state_q <= ST_CLEAR;
            instr_q <= NOP_WORD;
          end else if (wd_expired) begin
            state_q  <= ST_HALT;
            instr_q  <= NOP_WORD;
            busy_q   <= 1'b0;
            halted_q <= 1'b1;
            fault_q  <= 1'b1;
          end
        end

        ST_CLEAR: begin
          if (rearm) begin
            state_q <= ST_FETCH;
          end else begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
        end

        ST_HALT: begin
          instr_q <= NOP_WORD;
        end

        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.pc          = pc_q;
  assign bus.instruction = instr_q;
  assign bus.busy        = busy_q;
  assign bus.halted      = halted_q;
  assign bus.fault       = fault_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Randomised bench for instr_sequencer against an instruction-level model.
// Also covers the single-step build when SEQ_STEP_EN is defined.
module tb_instr_sequencer;

  import mcu_pkg::*;

  localparam int PC_W    = 8;
  localparam int TIMEOUT = 15;

  logic            clk;
  logic            rst;
  logic [15:0]     mem [256];

  // Instruction-level model state.
  logic [PC_W-1:0] m_pc;
  bit              m_halted;
  bit              m_fault;

  int n_checks;
  int n_fail;

  instr_sequencer_if #(.PC_W(PC_W)) bus ();

  instr_sequencer #(
    .PC_W    (PC_W),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  assign bus.mem_data = mem[bus.pc];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic fill_mem();
    logic [15:0] w;
    for (int i = 0; i < 256; i++) begin
      w = 16'($urandom);
      if (w[15:12] == OP_HALT) w[15:12] = OP_MOV;
      mem[i] = w;
    end
  endtask

  task automatic garbage();
    bus.done   = 1'($urandom);
    bus.pc_inc = 1'($urandom);
  endtask

  task automatic do_reset();
    bus.run    = 1'b0;
    bus.done   = 1'b0;
    bus.pc_inc = 1'b0;
`ifdef SEQ_STEP_EN
    bus.step   = 1'b0;
`endif
    rst = 1'b0;
    #1;
    check("rst_pc",     bus.pc,          0);
    check("rst_instr",  bus.instruction, NOP_WORD);
    check("rst_busy",   bus.busy,        0);
    check("rst_halted", bus.halted,      0);
    check("rst_fault",  bus.fault,       0);
    @(negedge clk);
    rst      = 1'b1;
    m_pc     = '0;
    m_halted = 1'b0;
    m_fault  = 1'b0;
  endtask

  task automatic idle_wait(input int n);
    repeat (n) begin
      garbage();
`ifdef SEQ_STEP_EN
      bus.run  = 1'($urandom);
      bus.step = 1'b0;
`else
      bus.run  = 1'b0;
`endif
      @(negedge clk);
      check("idle_busy",   bus.busy,        0);
      check("idle_halted", bus.halted,      0);
      check("idle_pc",     bus.pc,          m_pc);
      check("idle_instr",  bus.instruction, NOP_WORD);
    end
  endtask

  task automatic halt_hold(input int n);
    repeat (n) begin
      garbage();
      bus.run = 1'($urandom);
`ifdef SEQ_STEP_EN
      bus.step = 1'($urandom);
`endif
      @(negedge clk);
      check("halt_halted", bus.halted,      1);
      check("halt_busy",   bus.busy,        0);
      check("halt_fault",  bus.fault,       m_fault);
      check("halt_pc",     bus.pc,          m_pc);
      check("halt_instr",  bus.instruction, NOP_WORD);
    end
  endtask

  // Entered at a negedge where the next edge starts a FETCH (IDLE with run,
  // or CLEAR with run held). lat = EXEC cycle that raises done, 0 = never.
  task automatic do_instr(input int lat, input logic [31:0] inc_mask, input bit keep_run);
    logic [15:0] word;
    int          k;
    bit          fin;
    garbage();
    bus.run = 1'b1;
`ifdef SEQ_STEP_EN
    bus.step = 1'b1;
`endif
    @(negedge clk);
`ifdef SEQ_STEP_EN
    bus.step = 1'b0;
`endif
    check("fetch_busy", bus.busy, 1);
    check("fetch_pc",   bus.pc,   m_pc);
    garbage();
    @(negedge clk);
    check("load_pc",    bus.pc,          m_pc);
    check("load_instr", bus.instruction, NOP_WORD);
    garbage();
    @(negedge clk);
    word = mem[m_pc];
    if (word[15:12] == OP_HALT) begin
      m_halted = 1'b1;
      check("haltop_halted", bus.halted,      1);
      check("haltop_busy",   bus.busy,        0);
      check("haltop_instr",  bus.instruction, NOP_WORD);
      check("haltop_fault",  bus.fault,       m_fault);
      garbage();
      return;
    end
    k   = 1;
    fin = 1'b0;
    while (!fin) begin
      check("exec_instr", bus.instruction, word);
      check("exec_busy",  bus.busy,        1);
      check("exec_fault", bus.fault,       0);
      check("exec_pc",    bus.pc,          m_pc);
      bus.pc_inc = inc_mask[k-1];
      bus.done   = (k == lat);
      if (!keep_run) bus.run = 1'b0;
      @(negedge clk);
      if (inc_mask[k-1]) m_pc = m_pc + 8'd1;
      if (k == lat) begin
        fin = 1'b1;
      end else if (k == TIMEOUT) begin
        fin      = 1'b1;
        m_fault  = 1'b1;
        m_halted = 1'b1;
      end
      k++;
    end
    if (m_halted) begin
      check("tmo_halted", bus.halted,      1);
      check("tmo_fault",  bus.fault,       1);
      check("tmo_busy",   bus.busy,        0);
      check("tmo_instr",  bus.instruction, NOP_WORD);
    end else begin
      check("clear_instr",  bus.instruction, NOP_WORD);
      check("clear_busy",   bus.busy,        1);
      check("clear_halted", bus.halted,      0);
      check("clear_pc",     bus.pc,          m_pc);
    end
    garbage();
  endtask

  task automatic run_instr(input int lat, input logic [31:0] inc_mask, input bit keep_run);
    do_instr(lat, inc_mask, keep_run);
    if (!m_halted) begin
`ifdef SEQ_STEP_EN
      idle_wait(1 + int'($urandom_range(0, 2)));
`else
      if (!keep_run) idle_wait(1 + int'($urandom_range(0, 2)));
`endif
    end
  endtask

  task automatic reset_in_exec();
    bus.run = 1'b1;
`ifdef SEQ_STEP_EN
    bus.step = 1'b1;
`endif
    @(negedge clk);
`ifdef SEQ_STEP_EN
    bus.step = 1'b0;
`endif
    @(negedge clk);
    @(negedge clk);
    check("rx_exec_instr", bus.instruction, mem[m_pc]);
    bus.pc_inc = 1'b1;
    bus.done   = 1'b0;
    #2 rst = 1'b0;
    #1;
    check("rx_pc",     bus.pc,          0);
    check("rx_instr",  bus.instruction, NOP_WORD);
    check("rx_busy",   bus.busy,        0);
    check("rx_halted", bus.halted,      0);
    check("rx_fault",  bus.fault,       0);
    @(negedge clk);
    check("rx_pc_hold", bus.pc, 0);
    rst        = 1'b1;
    bus.pc_inc = 1'b0;
    bus.run    = 1'b0;
    m_pc       = '0;
    m_halted   = 1'b0;
    m_fault    = 1'b0;
  endtask

  initial begin
    n_checks   = 0;
    n_fail     = 0;
    rst        = 1'b1;
    bus.run    = 1'b0;
    bus.done   = 1'b0;
    bus.pc_inc = 1'b0;
`ifdef SEQ_STEP_EN
    bus.step   = 1'b0;
`endif
    m_pc     = '0;
    m_halted = 1'b0;
    m_fault  = 1'b0;
    fill_mem();
    mem[0] = 16'h4041;
    mem[1] = 16'hF000;

    #1 do_reset();
    idle_wait(2);

    // Two-word program: MOV with one pc_inc, then HALT.
    run_instr(2, 32'h1, 1'b1);
    check("mov_pc", bus.pc, 1);
    do_instr(1, 32'h0, 1'b1);
    check("mov_halted", bus.halted, 1);
    check("mov_fault",  bus.fault,  0);
    halt_hold(3);
    do_reset();
    fill_mem();
    idle_wait(1);

    // Watchdog boundary: done on the expiry cycle wins, absent done faults.
    run_instr(TIMEOUT, $urandom, 1'b1);
    check("tmo_edge_fault", bus.fault, 0);
    run_instr(0, $urandom, 1'b1);
    check("tmo_fault_set", bus.fault, 1);
    halt_hold(3);
    do_reset();

    // Drive the PC to all-ones, then one more increment wraps it to zero.
    for (int i = 0; i < 17; i++) run_instr(TIMEOUT, 32'hFFFF_FFFF, 1'b1);
    check("pre_wrap_pc", bus.pc, 8'hFF);
    run_instr(1, 32'h1, 1'b1);
    check("wrap_pc", bus.pc, 8'h00);

    // Run dropped during EXEC: instruction finishes, then IDLE.
    run_instr(4, $urandom, 1'b0);
    idle_wait(3);

    for (int i = 0; i < 60; i++) begin
      int lat;
      bit keep;
      lat  = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, TIMEOUT));
      keep = ($urandom_range(0, 3) != 0);
      run_instr(lat, $urandom, keep);
      if (m_halted) begin
        halt_hold(2);
        do_reset();
      end
    end

    run_instr(3, 32'h7, 1'b1);
    reset_in_exec();
    idle_wait(1);
    run_instr(2, 32'h3, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
